serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter N SHALL be: N, default 4, operand/result width in bits (N >= 1).
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be: clk  input  1  rising-edge clock.
REQ-004 Port rst SHALL be: rst  input  1  synchronous active-high reset.
REQ-005 Port start SHALL be: start  input  1  request a new operation.
REQ-006 Port borrow_in SHALL be: borrow_in  input  1  incoming borrow, captured with the operands.
REQ-007 Ports op1 and op2 SHALL be: op1, op2  input  N  minuend and subtrahend, captured on an accepted start.
REQ-008 Port ready SHALL be: ready  output  1  high while idle, when start is accepted.
REQ-009 Port done SHALL be: done  output  1  one-cycle pulse when a new result is on diff and borrow_out.
REQ-010 Port diff SHALL be: diff  output  N  registered difference.
REQ-011 Port borrow_out SHALL be: borrow_out  output  1  registered final borrow.

Function
REQ-012 The block SHALL compute diff = (op1 - op2 - borrow_in) mod 2^N, one bit per clock, LSB first.
REQ-013 borrow_out SHALL be 1 iff op1 < op2 + borrow_in (unsigned).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE SHALL hold ready=1 and SHALL go to RUN on a clk edge with start=1.
- At that edge op1, op2 and borrow_in are latched into internal shift and borrow registers.
- The bit counter is cleared.
REQ-016 In RUN, each edge SHALL compute one bit from the current LSBs and the borrow register, then shift both operand registers and increment the counter.
REQ-017 After N RUN edges the FSM SHALL enter DONE, and diff and borrow_out SHALL load at that same edge.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency from the start-sampling edge to done=1 SHALL be N cycles, giving one operation per N+2 cycles.
REQ-020 ready SHALL be 0 in RUN and DONE, and start in those states SHALL be ignored without disturbing the operation.
REQ-021 diff and borrow_out SHALL hold the previous result through IDLE and RUN, changing only on entry to DONE.
REQ-022 Changes to op1, op2 or borrow_in after acceptance SHALL have no effect on the running operation.
REQ-023 For N=1 the block SHALL spend one cycle in RUN, with identical handshake behaviour.
REQ-024 The bit counter SHALL be $clog2(N+1) bits wide.

Reset
REQ-025 When rst=1 at a clk edge, the FSM SHALL go to IDLE and the counter, diff, borrow_out and the internal borrow register SHALL clear to 0.
REQ-026 After reset, ready SHALL be 1 and done SHALL be 0.
REQ-027 rst SHALL have priority over start.
REQ-028 A reset during RUN or DONE SHALL abort the operation, with no done pulse and no result update.

Structure
REQ-029 Package serial_sub_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and nothing block-specific beyond it.
REQ-030 Per-bit arithmetic SHALL live in sub-module full_subtractor.
- Inputs a, b, bin; outputs d, bout.
- d = a^b^bin.
- bout = (~a&b) | (~a&bin) | (b&bin).
REQ-031 serial_subtractor SHALL instantiate exactly one full_subtractor.

Verification
REQ-032 The bench SHALL cover: N=3, op1=5, op2=3, borrow_in=0 -> done exactly 3 cycles after the start edge, diff=2, borrow_out=0.
REQ-033 The bench SHALL cover: N=3, op1=3, op2=5, borrow_in=0 -> diff=6, borrow_out=1; then op1=0, op2=0, borrow_in=1 -> diff=7, borrow_out=1.
REQ-034 The bench SHALL cover: start held high through RUN with operands changed to 7/7 -> first result unaffected; second op starts only after ready returns (N+2 cycles per op).
REQ-035 The bench SHALL cover: rst asserted on the 2nd RUN cycle -> no done pulse, diff=0, borrow_out=0, ready=1 one edge later.
REQ-036 The bench SHALL cover: N=3 exhaustive sweep of all op1, op2, borrow_in -> {borrow_out,diff} equals (op1 - op2 - borrow_in) mod 16 on every done.
REQ-037 The bench SHALL cover: N=1, all 8 input combinations -> done one cycle after start, correct results.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: a - b - bin, producing difference and borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one difference bit per clock, LSB first, with a
// start/ready/done handshake and registered results.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         borrow_in,
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   res_sr;
  logic [N-1:0]   res_next;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           bit_d;
  logic           bit_bout;

  full_subtractor u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (bit_d),
    .bout(bit_bout)
  );

  // New difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
  always_comb begin
    res_next        = res_sr >> 1;
    res_next[N-1]   = bit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= op1;
            b_sr   <= op2;
            borrow <= borrow_in;
            cnt    <= '0;
            state  <= RUN;
            ready  <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bit_bout;
          res_sr <= res_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state      <= DONE;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bit_bout;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, exercising an N=3 and an N=1 instance.
module tb_serial_subtractor;

  typedef struct {
    int val;
    int due;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  sb_t        q3[$];
  sb_t        q1[$];
  sb_t        e3;
  sb_t        e1;

  logic       start3, bin3, ready3, done3, bo3;
  logic [2:0] op1_3, op2_3, diff3;
  logic       start1, bin1, ready1, done1, bo1;
  logic [0:0] op1_1, op2_1, diff1;

  serial_subtractor #(.N(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .borrow_in (bin3),
    .op1       (op1_3),
    .op2       (op2_3),
    .ready     (ready3),
    .done      (done3),
    .diff      (diff3),
    .borrow_out(bo3)
  );

  serial_subtractor #(.N(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .borrow_in (bin1),
    .op1       (op1_1),
    .op2       (op2_1),
    .ready     (ready1),
    .done      (done1),
    .diff      (diff1),
    .borrow_out(bo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {borrow_out, diff} as an (n+1)-bit two's-complement wrap of the true difference.
  function automatic int exp_val(input int a, input int b, input int c, input int n);
    return (a - b - c) & ((1 << (n + 1)) - 1);
  endfunction

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) check_eq("done3_unexpected", done3, 0);
      else begin
        e3 = q3.pop_front();
        check_eq("result3", {bo3, diff3}, e3.val);
        check_eq("latency3", cyc, e3.due);
      end
    end
    if (done1) begin
      if (q1.size() == 0) check_eq("done1_unexpected", done1, 0);
      else begin
        e1 = q1.pop_front();
        check_eq("result1", {bo1, diff1}, e1.val);
        check_eq("latency1", cyc, e1.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic op3(input int a, input int b, input int c, input bit expect_done);
    int t = 0;
    while (!ready3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready3_wait", ready3, 1);
    start3 = 1'b1;
    op1_3  = 3'(a);
    op2_3  = 3'(b);
    bin3   = c[0];
    @(posedge clk);
    #1;
    if (expect_done) q3.push_back('{val: exp_val(a, b, c, 3), due: cyc + 3});
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic op1(input int a, input int b, input int c);
    int t = 0;
    while (!ready1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready1_wait", ready1, 1);
    start1 = 1'b1;
    op1_1  = 1'(a);
    op2_1  = 1'(b);
    bin1   = c[0];
    @(posedge clk);
    #1;
    q1.push_back('{val: exp_val(a, b, c, 1), due: cyc + 1});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q3.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_q3", q3.size(), 0);
    check_eq("drain_q1", q1.size(), 0);
  endtask

  initial begin
    int s1;
    rst    = 1'b1;
    start3 = 1'b0; bin3 = 1'b0; op1_3 = '0; op2_3 = '0;
    start1 = 1'b0; bin1 = 1'b0; op1_1 = '0; op2_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready3", ready3, 1);
    check_eq("rst_done3", done3, 0);
    check_eq("rst_diff3", diff3, 0);
    check_eq("rst_bo3", bo3, 0);
    check_eq("rst_ready1", ready1, 1);
    check_eq("rst_done1", done1, 0);
    rst = 1'b0;
    @(negedge clk);

    op3(5, 3, 0, 1'b1);
    drain();
    op3(3, 5, 0, 1'b1);
    op3(0, 0, 1, 1'b1);
    drain();

    // Start held through RUN with operands switched to 7/7 after acceptance.
    start3 = 1'b1; op1_3 = 3'd6; op2_3 = 3'd2; bin3 = 1'b0;
    @(posedge clk);
    #1;
    s1 = cyc;
    q3.push_back('{val: exp_val(6, 2, 0, 3), due: s1 + 3});
    q3.push_back('{val: exp_val(7, 7, 0, 3), due: s1 + 8});
    @(negedge clk);
    op1_3 = 3'd7; op2_3 = 3'd7;
    @(negedge clk);
    check_eq("run_ready3", ready3, 0);
    check_eq("run_diff_hold", diff3, 7);
    check_eq("run_bo_hold", bo3, 1);
    while (cyc < s1 + 5) @(negedge clk);
    start3 = 1'b0;
    drain();

    // Reset during the second RUN cycle aborts the operation.
    op3(1, 2, 0, 1'b1);
    drain();
    op3(6, 1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready3", ready3, 1);
    check_eq("abort_done3", done3, 0);
    check_eq("abort_diff3", diff3, 0);
    check_eq("abort_bo3", bo3, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          op3(a, b, c, 1'b1);
    drain();

    for (int k = 0; k < 8; k++) op1(k >> 2, (k >> 1) & 1, k & 1);
    drain();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
